// File: rtl/line_blend_pkg.sv
// Shared types and pixel arithmetic for the vertical line blend stage.
package line_blend_pkg;

  localparam int unsigned RGB_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Halving each term first keeps the sum within 8 bits.
  function automatic rgb_t rgb_avg(input rgb_t a, input rgb_t b);
    rgb_t o;
    o.r = (a.r >> 1) + (b.r >> 1);
    o.g = (a.g >> 1) + (b.g >> 1);
    o.b = (a.b >> 1) + (b.b >> 1);
    return o;
  endfunction

  function automatic logic [7:0] dim8(input logic [7:0] c, input logic [1:0] lvl);
    logic [7:0] o;
    unique case (lvl)
      2'd0:    o = c;
      2'd1:    o = c - (c >> 2);
      2'd2:    o = c >> 1;
      default: o = c >> 2;
    endcase
    return o;
  endfunction

  function automatic rgb_t rgb_dim(input rgb_t c, input logic [1:0] lvl);
    rgb_t o;
    o.r = dim8(c.r, lvl);
    o.g = dim8(c.g, lvl);
    o.b = dim8(c.b, lvl);
    return o;
  endfunction

endpackage

// File: rtl/line_blend_ram.sv
// Line buffer: simple dual-port, registered read returning old data on collision.
module line_blend_ram #(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 24
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [MAX_WIDTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/line_blend.sv
// Two-stage vertical 50/50 blend against the previous line's pixel at the same column.
// Optional scanline dimming on odd lines with LINE_BLEND_SCANLINE_EN.
module line_blend
  import line_blend_pkg::*;
#(
  parameter int unsigned MAX_WIDTH = 1024,
  parameter int unsigned AW        = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  input  logic       enable,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       hs,
  input  logic       vs,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
`ifdef LINE_BLEND_SCANLINE_EN
  input  logic [1:0] scan_lvl,
`endif
  output logic       hblank_out,
  output logic       vblank_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic [7:0] red_out,
  output logic [7:0] green_out,
  output logic [7:0] blue_out
);

  localparam logic [AW:0] XMax = (AW+1)'(MAX_WIDTH);
  localparam logic [AW:0] XOne = {{AW{1'b0}}, 1'b1};

  logic        active, in_range;
  logic [AW:0] x_q;
  rgb_t        pix_in, prev, pix_q, out_q, blend_c, result_c;
  logic [RGB_W-1:0] ram_rdata;
  logic        hb1_q, vb1_q, hs1_q, vs1_q, act1_q, rng1_q;
  logic        hb2_q, vb2_q, hs2_q, vs2_q;
  logic        line_active_q, prev_valid_q;
`ifdef LINE_BLEND_SCANLINE_EN
  logic        parity_q;
`endif

  assign active   = !hblank && !vblank;
  assign in_range = (x_q < XMax);
  assign pix_in   = '{r: red, g: green, b: blue};
  assign prev     = ram_rdata;

  line_blend_ram #(
    .MAX_WIDTH (MAX_WIDTH),
    .AW        (AW),
    .DW        (RGB_W)
  ) u_ram (
    .clk   (clk),
    .ce    (pix_ce),
    .we    (active && in_range),
    .waddr (x_q[AW-1:0]),
    .wdata (pix_in),
    .raddr (x_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Column counter saturates at MAX_WIDTH so over-long lines stop storing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
    end else if (pix_ce) begin
      if (hblank)                  x_q <= '0;
      else if (active && in_range) x_q <= x_q + XOne;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_active_q <= 1'b0;
      prev_valid_q  <= 1'b0;
`ifdef LINE_BLEND_SCANLINE_EN
      parity_q      <= 1'b0;
`endif
    end else if (pix_ce) begin
      if (vblank) begin
        line_active_q <= 1'b0;
        prev_valid_q  <= 1'b0;
`ifdef LINE_BLEND_SCANLINE_EN
        parity_q      <= 1'b0;
`endif
      end else if (hblank && line_active_q) begin
        line_active_q <= 1'b0;
        prev_valid_q  <= 1'b1;
`ifdef LINE_BLEND_SCANLINE_EN
        parity_q      <= ~parity_q;
`endif
      end else if (active) begin
        line_active_q <= 1'b1;
      end
    end
  end

  always_comb begin
    blend_c = pix_q;
    if (enable && prev_valid_q && act1_q && rng1_q) blend_c = rgb_avg(prev, pix_q);
    result_c = blend_c;
`ifdef LINE_BLEND_SCANLINE_EN
    if (parity_q) result_c = rgb_dim(blend_c, scan_lvl);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q  <= '0;
      hb1_q  <= 1'b0;
      vb1_q  <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      act1_q <= 1'b0;
      rng1_q <= 1'b0;
      out_q  <= '0;
      hb2_q  <= 1'b0;
      vb2_q  <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
    end else if (pix_ce) begin
      pix_q  <= pix_in;
      hb1_q  <= hblank;
      vb1_q  <= vblank;
      hs1_q  <= hs;
      vs1_q  <= vs;
      act1_q <= active;
      rng1_q <= in_range;
      out_q  <= result_c;
      hb2_q  <= hb1_q;
      vb2_q  <= vb1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign hblank_out = hb2_q;
  assign vblank_out = vb2_q;
  assign hs_out     = hs2_q;
  assign vs_out     = vs2_q;
  assign red_out    = out_q.r;
  assign green_out  = out_q.g;
  assign blue_out   = out_q.b;

endmodule

// File: tb/tb_line_blend.sv
// Directed bench for line_blend: full-width DUT plus a MAX_WIDTH=4 DUT on shared stimulus.
module tb_line_blend;

  logic       clk = 1'b0;
  logic       reset_n, pix_ce, enable, hblank, vblank, hs, vs;
  logic [7:0] red, green, blue;
`ifdef LINE_BLEND_SCANLINE_EN
  logic [1:0] scan_lvl;
`endif
  logic       hb_o, vb_o, hs_o, vs_o;
  logic [7:0] r_o, g_o, b_o;
  logic       s_hb, s_vb, s_hs, s_vs;
  logic [7:0] s_r, s_g, s_b;

  int checks = 0;
  int errors = 0;
  logic gap = 1'b0, chk_small = 1'b0, have_prev = 1'b0;
  logic [7:0] bval;
  // expectation for the pixel presented on the previous pix_ce
  logic [7:0] e_val, e_small;
  logic       e_hb, e_vb, e_hs, e_vs;

  always #5 clk = ~clk;

  line_blend dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .enable(enable),
    .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs),
    .red(red), .green(green), .blue(blue),
`ifdef LINE_BLEND_SCANLINE_EN
    .scan_lvl(scan_lvl),
`endif
    .hblank_out(hb_o), .vblank_out(vb_o), .hs_out(hs_o), .vs_out(vs_o),
    .red_out(r_o), .green_out(g_o), .blue_out(b_o)
  );

  line_blend #(.MAX_WIDTH(4), .AW(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .enable(enable),
    .hblank(hblank), .vblank(vblank), .hs(hs), .vs(vs),
    .red(red), .green(green), .blue(blue),
`ifdef LINE_BLEND_SCANLINE_EN
    .scan_lvl(scan_lvl),
`endif
    .hblank_out(s_hb), .vblank_out(s_vb), .hs_out(s_hs), .vs_out(s_vs),
    .red_out(s_r), .green_out(s_g), .blue_out(s_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string ph);
    check({ph, " red"},   32'(r_o),  32'(e_val));
    check({ph, " green"}, 32'(g_o),  32'(e_val));
    check({ph, " blue"},  32'(b_o),  32'(e_val));
    check({ph, " syncs"}, 32'({hb_o, vb_o, hs_o, vs_o}), 32'({e_hb, e_vb, e_hs, e_vs}));
    if (chk_small) begin
      check({ph, " small rgb"}, 32'({s_r, s_g, s_b}), 32'({3{e_small}}));
      check({ph, " small syncs"}, 32'({s_hb, s_vb, s_hs, s_vs}),
            32'({e_hb, e_vb, e_hs, e_vs}));
    end
  endtask

  // One pix_ce; checks the output for the previous pixel, then holds through idle cycles.
  task automatic pix(input logic hb, input logic vb, input logic h, input logic v,
                     input logic [7:0] val, input logic [7:0] exp, input logic [7:0] exps);
    hblank = hb; vblank = vb; hs = h; vs = v;
    red = val; green = val; blue = val;
    pix_ce = 1'b1;
    @(posedge clk); #1;
    if (have_prev) check_out("pix");
    if (gap) begin
      for (int i = 0; i < 3; i++) begin
        pix_ce = 1'b0;
        {hblank, vblank, hs, vs} = 4'($urandom);
        red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
        @(posedge clk); #1;
        if (have_prev) check_out("idle");
      end
    end
    pix_ce = 1'b0;
    e_val = exp; e_small = exps;
    e_hb = hb; e_vb = vb; e_hs = h; e_vs = v;
    have_prev = 1'b1;
  endtask

  task automatic line(input logic [7:0] val, input logic [7:0] exp,
                      input logic [7:0] exps_lo, input logic [7:0] exps_hi, input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, val, exp, (i < 4) ? exps_lo : exps_hi);
    pix(1'b1, 1'b0, 1'b0, 1'b0, bval, bval, bval);
    pix(1'b1, 1'b0, 1'b1, 1'b0, bval, bval, bval);
  endtask

  task automatic vbl();
    pix(1'b1, 1'b1, 1'b0, 1'b1, bval, bval, bval);
    pix(1'b1, 1'b1, 1'b0, 1'b1, bval, bval, bval);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    e_val = 8'h00; e_small = 8'h00;
    e_hb = 1'b0; e_vb = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
    chk_small = 1'b1;
    check_out("reset");
    chk_small = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    have_prev = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; pix_ce = 1'b0; enable = 1'b1;
    hblank = 1'b0; vblank = 1'b0; hs = 1'b0; vs = 1'b0;
    red = 8'h00; green = 8'h00; blue = 8'h00;
    bval = 8'h5a;
`ifdef LINE_BLEND_SCANLINE_EN
    scan_lvl = 2'd0;
`endif
    #2;
    do_reset();

    // Blend on: 0x00, then 0x00/2+0x10/2, then 0x10/2+0x20/2
    line(8'h00, 8'h00, 8'h00, 8'h00, 8);
    line(8'h10, 8'h08, 8'h00, 8'h00, 8);
    line(8'h20, 8'h18, 8'h00, 8'h00, 8);

    // Bypass: pure 2-pix_ce delay
    enable = 1'b0;
    line(8'h00, 8'h00, 8'h00, 8'h00, 8);
    line(8'h10, 8'h10, 8'h00, 8'h00, 8);
    line(8'h20, 8'h20, 8'h00, 8'h00, 8);

    // RAM kept filling while bypassed; vblank then invalidates the previous line
    enable = 1'b1;
    line(8'h00, 8'h10, 8'h00, 8'h00, 8);
    vbl();
    line(8'hff, 8'hff, 8'h00, 8'h00, 8);
    line(8'hff, 8'hfe, 8'h00, 8'h00, 8);

    // Small DUT: columns past MAX_WIDTH pass through and are not stored
    chk_small = 1'b1;
    line(8'h00, 8'h7f, 8'h7f, 8'h00, 8);
    line(8'h80, 8'h40, 8'h40, 8'h80, 6);
    chk_small = 1'b0;

    // Mid-line reset, then the first run again with pix_ce 1-in-4
    pix(1'b0, 1'b0, 1'b0, 1'b0, 8'h33, 8'h59, 8'h59);
    do_reset();
    gap = 1'b1;
    line(8'h00, 8'h00, 8'h00, 8'h00, 8);
    line(8'h10, 8'h08, 8'h00, 8'h00, 8);
    line(8'h20, 8'h18, 8'h00, 8'h00, 8);
    gap = 1'b0;

`ifdef LINE_BLEND_SCANLINE_EN
    enable = 1'b0;
    bval = 8'h00;
    vbl();
    scan_lvl = 2'd2;
    line(8'hc8, 8'hc8, 8'h00, 8'h00, 8);
    line(8'hc8, 8'h64, 8'h00, 8'h00, 8);
    line(8'hc8, 8'hc8, 8'h00, 8'h00, 8);
    scan_lvl = 2'd3;
    line(8'hc8, 8'h32, 8'h00, 8'h00, 8);
`endif

    pix(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
